// File: rtl/ps2_keyboard.sv
// ps2_keyboard
//   Receives scan-code set 2 bytes from a PS/2 keyboard and presents the Hack
//   keycode of the currently held key (0 when none). The output drives the
//   Hack keyboard register directly.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   ps2_clk    in   raw PS/2 clock line (asynchronous)
//   ps2_data   in   raw PS/2 data line (asynchronous)
//   keycode    out  [15:0] Hack keycode of held key, 0 when none
//   scan_byte  out  [7:0] last correctly framed byte
//   scan_valid out  one-cycle strobe, scan_byte just updated
//   frame_err  out  one-cycle strobe on parity, stop or timeout error
module ps2_keyboard #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic [7:0]  scan_byte,
  output logic        scan_valid,
  output logic        frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]     r_clkSync, r_dataSync;
  logic           r_filtClk;
  logic [FCW-1:0] r_filtCnt;
  logic           w_clkS, w_dataS, w_filtFlip, w_fall;

  state_t         r_state, w_stateNext;
  logic [2:0]     r_bitCnt, w_bitCntNext;
  logic [7:0]     r_shift, w_shiftNext;
  logic           r_parity, w_parityNext;
  logic [TCW-1:0] r_idleCnt, w_idleCntNext;
  logic           w_validNext, w_errNext;

  logic           r_scanValid, r_frameErr;
  logic [7:0]     r_scanByte;
  logic           r_ext, r_brk;
  logic [15:0]    r_keycode, w_mapped;

  assign w_clkS  = r_clkSync[1];
  assign w_dataS = r_dataSync[1];

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample;
  // a 1->0 flip is the single-cycle fall event that samples data.
  assign w_filtFlip = (w_clkS != r_filtClk) && (r_filtCnt == FCW'(FILTER_LEN - 1));
  assign w_fall     = w_filtFlip && r_filtClk;

  // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
    end
  end

  // Glitch filter: count consecutive samples disagreeing with the filtered
  // level, restart the count on any agreeing sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filtClk <= 1'b1;
      r_filtCnt <= '0;
    end else if (w_clkS == r_filtClk) begin
      r_filtCnt <= '0;
    end else if (w_filtFlip) begin
      r_filtClk <= w_clkS;
      r_filtCnt <= '0;
    end else begin
      r_filtCnt <= r_filtCnt + FCW'(1);
    end
  end

  // Frame deserializer next-state logic. A stalled frame is abandoned once the
  // idle counter reaches TIMEOUT; that check takes priority over a late fall.
  always_comb begin
    w_stateNext   = r_state;
    w_bitCntNext  = r_bitCnt;
    w_shiftNext   = r_shift;
    w_parityNext  = r_parity;
    w_validNext   = 1'b0;
    w_errNext     = 1'b0;
    w_idleCntNext = (r_state == IDLE || w_fall) ? '0 : r_idleCnt + TCW'(1);
    if (r_state != IDLE && r_idleCnt == TCW'(TIMEOUT)) begin
      w_stateNext   = IDLE;
      w_errNext     = 1'b1;
      w_shiftNext   = '0;
      w_idleCntNext = '0;
    end else if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_dataS) begin
            w_bitCntNext = '0;
            w_stateNext  = DATA;
          end
        end
        DATA: begin
          w_shiftNext  = {w_dataS, r_shift[7:1]};
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) w_stateNext = PARITY;
        end
        PARITY: begin
          w_parityNext = w_dataS;
          w_stateNext  = STOP;
        end
        STOP: begin
          if (w_dataS && (^{r_shift, r_parity})) w_validNext = 1'b1;
          else                                   w_errNext   = 1'b1;
          w_stateNext = IDLE;
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // Frame state and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_idleCnt   <= '0;
      r_scanValid <= 1'b0;
      r_frameErr  <= 1'b0;
      r_scanByte  <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_bitCnt    <= w_bitCntNext;
      r_shift     <= w_shiftNext;
      r_parity    <= w_parityNext;
      r_idleCnt   <= w_idleCntNext;
      r_scanValid <= w_validNext;
      r_frameErr  <= w_errNext;
      if (w_validNext) r_scanByte <= r_shift;
    end
  end

  // Set-2 to Hack map. Zero means unmapped; E0-prefixed codes only map arrows.
  function automatic logic [15:0] mapCode(input logic [7:0] code, input logic ext);
    logic [15:0] v;
    v = 16'h0000;
    if (ext) begin
      case (code)
        8'h6B: v = 16'd130;
        8'h75: v = 16'd131;
        8'h74: v = 16'd132;
        8'h72: v = 16'd133;
        default: v = 16'h0000;
      endcase
    end else begin
      case (code)
        8'h1C: v = 16'h41; 8'h32: v = 16'h42; 8'h21: v = 16'h43; 8'h23: v = 16'h44;
        8'h24: v = 16'h45; 8'h2B: v = 16'h46; 8'h34: v = 16'h47; 8'h33: v = 16'h48;
        8'h43: v = 16'h49; 8'h3B: v = 16'h4A; 8'h42: v = 16'h4B; 8'h4B: v = 16'h4C;
        8'h3A: v = 16'h4D; 8'h31: v = 16'h4E; 8'h44: v = 16'h4F; 8'h4D: v = 16'h50;
        8'h15: v = 16'h51; 8'h2D: v = 16'h52; 8'h1B: v = 16'h53; 8'h2C: v = 16'h54;
        8'h3C: v = 16'h55; 8'h2A: v = 16'h56; 8'h1D: v = 16'h57; 8'h22: v = 16'h58;
        8'h35: v = 16'h59; 8'h1A: v = 16'h5A;
        8'h45: v = 16'h30; 8'h16: v = 16'h31; 8'h1E: v = 16'h32; 8'h26: v = 16'h33;
        8'h25: v = 16'h34; 8'h2E: v = 16'h35; 8'h36: v = 16'h36; 8'h3D: v = 16'h37;
        8'h3E: v = 16'h38; 8'h46: v = 16'h39;
        8'h29: v = 16'h20;
        8'h5A: v = 16'd128;
        8'h66: v = 16'd129;
        8'h76: v = 16'd140;
        default: v = 16'h0000;
      endcase
    end
    return v;
  endfunction

  assign w_mapped = mapCode(r_scanByte, r_ext);

  // Make/break decoder driven by accepted bytes; prefixes only set flags, and
  // a break clears the keycode only when it releases the key being shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_keycode <= '0;
    end else if (r_scanValid) begin
      if (r_scanByte == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_scanByte == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (w_mapped != 16'h0000) begin
          if (!r_brk)                    r_keycode <= w_mapped;
          else if (w_mapped == r_keycode) r_keycode <= '0;
        end
      end
    end
  end

  assign keycode    = r_keycode;
  assign scan_byte  = r_scanByte;
  assign scan_valid = r_scanValid;
  assign frame_err  = r_frameErr;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard
//   Self-checking bench for ps2_keyboard: drives PS/2 frames, keeps a queue of
//   expected scan events and compares keycode after each frame.
module tb_ps2_keyboard;

  localparam int FILTER_LEN = 8;
  localparam int TB_TIMEOUT = 1000;
  localparam int HALF       = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2Clk = 1'b1;
  logic        ps2Data = 1'b1;
  logic [15:0] keycode;
  logic [7:0]  scanByte;
  logic        scanValid;
  logic        frameErr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       isErr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0]  code;
    logic        badPar;
    logic        badStop;
    logic [15:0] expKey;
  } vec_t;

  ev_t  expQ[$];
  vec_t vecs[$];

  ps2_keyboard #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2Clk),
    .ps2_data(ps2Data),
    .keycode(keycode),
    .scan_byte(scanByte),
    .scan_valid(scanValid),
    .frame_err(frameErr)
  );

  always #5 clk = ~clk;

  // Global watchdog so a stuck run still ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if (scanValid && frameErr) begin
        total++;
        bad++;
        $display("[TB] FAIL strobeOverlap: got valid=1 err=1 expected exclusive");
      end else if (scanValid || frameErr) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedEvent: got valid=%0d err=%0d byte=%h expected none",
                   scanValid, frameErr, scanByte);
        end else begin
          ev_t ev;
          ev = expQ.pop_front();
          checkOutput("eventKind", {15'b0, frameErr}, {15'b0, ev.isErr});
          if (!ev.isErr) checkOutput("scanByte", {8'b0, scanByte}, {8'b0, ev.data});
        end
      end
    end
  end

  task automatic sendBit(input logic v);
    @(negedge clk) ps2Data = v;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  // Same as sendBit but with a short low glitch while the clock is high.
  task automatic sendBitGlitch(input logic v);
    @(negedge clk) ps2Data = v;
    repeat (HALF / 4) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (FILTER_LEN - 2) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (HALF - HALF / 4 - (FILTER_LEN - 2)) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic badPar, input logic badStop,
                           input logic glitch);
    logic par;
    par = ~(^b) ^ badPar;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (glitch) sendBitGlitch(b[i]);
      else        sendBit(b[i]);
    end
    sendBit(par);
    sendBit(~badStop);
    @(negedge clk) ps2Data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    ev_t ev;
    ev.isErr = v.badPar | v.badStop;
    ev.data  = v.code;
    expQ.push_back(ev);
    sendFrame(v.code, v.badPar, v.badStop, 1'b0);
    checkOutput({name, "_pending"}, 16'(expQ.size()), 16'd0);
    checkOutput({name, "_keycode"}, keycode, v.expKey);
  endtask

  initial begin
    ev_t ev;
    vec_t v;
    int  waited;

    // Reset values.
    repeat (5) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_keycode", keycode, 16'h0000);
    checkOutput("rst_scanByte", {8'b0, scanByte}, 16'h0000);
    checkOutput("rst_scanValid", {15'b0, scanValid}, 16'h0000);
    checkOutput("rst_frameErr", {15'b0, frameErr}, 16'h0000);
    repeat (5) @(negedge clk);

    // First frame 0x1C with latency check around the stop-bit fall.
    ev.isErr = 1'b0;
    ev.data  = 8'h1C;
    expQ.push_back(ev);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(ev.data[i]);
    sendBit(~(^ev.data));
    @(negedge clk) ps2Data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    waited = 0;
    while (!scanValid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("lat_validSeen", {15'b0, scanValid}, 16'h0001);
    checkOutput("lat_keyBefore", keycode, 16'h0000);
    @(negedge clk);
    checkOutput("lat_keyAfter", keycode, 16'h0041);
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (10) @(negedge clk);

    // Table of frames and expected keycode after each.
    vecs.push_back('{8'h32, 1'b0, 1'b0, 16'h0042});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 16'h0042});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 16'h0042});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 16'h0042});
    vecs.push_back('{8'h32, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 16'h0083});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 16'h0083});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 16'h0083});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 16'h0041});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 16'h0041});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{8'h1C, 1'b1, 1'b0, 16'h0000});
    vecs.push_back('{8'h1C, 1'b0, 1'b1, 16'h0000});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 16'h0041});
    vecs.push_back('{8'h46, 1'b0, 1'b0, 16'h0039});
    vecs.push_back('{8'h5A, 1'b0, 1'b0, 16'h0080});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 16'h0080});
    vecs.push_back('{8'h5A, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{8'h76, 1'b0, 1'b0, 16'h008C});
    vecs.push_back('{8'h6B, 1'b0, 1'b0, 16'h008C});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 16'h008C});
    vecs.push_back('{8'h6B, 1'b0, 1'b0, 16'h0082});
    vecs.push_back('{8'h66, 1'b0, 1'b0, 16'h0081});
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v, $sformatf("vec%0d", i));
    end

    // Stall after four data bits: one timeout error, then a good frame.
    ev.isErr = 1'b1;
    ev.data  = 8'h00;
    expQ.push_back(ev);
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    repeat (TB_TIMEOUT + 10) @(negedge clk);
    checkOutput("timeout_pending", 16'(expQ.size()), 16'd0);
    applyStimulus('{8'h16, 1'b0, 1'b0, 16'h0031}, "afterTimeout");

    // Short clock glitches inside every data bit must not add samples.
    ev.isErr = 1'b0;
    ev.data  = 8'h1C;
    expQ.push_back(ev);
    sendFrame(8'h1C, 1'b0, 1'b0, 1'b1);
    checkOutput("glitch_pending", 16'(expQ.size()), 16'd0);
    checkOutput("glitch_keycode", keycode, 16'h0041);

    // Reset in the middle of a frame discards everything.
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    ps2Data = 1'b1;
    checkOutput("midRst_keycode", keycode, 16'h0000);
    checkOutput("midRst_scanByte", {8'b0, scanByte}, 16'h0000);
    checkOutput("midRst_scanValid", {15'b0, scanValid}, 16'h0000);
    checkOutput("midRst_frameErr", {15'b0, frameErr}, 16'h0000);
    repeat (30) @(negedge clk);
    applyStimulus('{8'h29, 1'b0, 1'b0, 16'h0020}, "afterReset");

    repeat (20) @(negedge clk);
    checkOutput("final_pending", 16'(expQ.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
